ks_pipe_adder: RTL and testbench

- Parametrised, fully pipelined Kogge-Stone adder/subtractor. Successor to the combinational 16-bit prefix adder.
- Generalises width, registers every prefix level, and adds subtract mode, signed overflow and a valid/ready stream handshake.
- Sits in the datapath wherever a multi-cycle, high-fmax add is needed; one operation accepted per clock when not stalled.

---
 rtl/ks_pipe_adder_if.sv | 40 ++++
 rtl/ks_pipe_adder.sv | 142 ++++++++++++++
 tb/tb_ks_pipe_adder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ks_pipe_adder_if.sv
// ---------------------------------------------------------------------------
// ks_pipe_adder_if
// Stream interface for the pipelined Kogge-Stone adder/subtractor.
//   master : the side that issues operands and consumes results
//   slave  : the adder itself
// Signals:
//   IN_VALID / IN_READY   operand beat handshake
//   A, B                  operands (WIDTH bits)
//   CIN                   carry-in (ignored when SUB=1)
//   SUB                   0 = A+B+CIN, 1 = A-B
//   OUT_VALID / OUT_READY result beat handshake
//   SUM                   result (WIDTH bits)
//   COUT                  carry out of the MSB (1 = no borrow when SUB=1)
//   OVF                   two's-complement signed overflow
// ---------------------------------------------------------------------------
interface ks_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIN;
    logic             SUB;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] SUM;
    logic             COUT;
    logic             OVF;

    modport master (
        output IN_VALID, A, B, CIN, SUB, OUT_READY,
        input  IN_READY, OUT_VALID, SUM, COUT, OVF
    );

    modport slave (
        input  IN_VALID, A, B, CIN, SUB, OUT_READY,
        output IN_READY, OUT_VALID, SUM, COUT, OVF
    );
endinterface

// File: rtl/ks_pipe_adder.sv
// ---------------------------------------------------------------------------
// ks_pipe_adder
// Fully pipelined Kogge-Stone adder/subtractor with a valid/ready stream
// handshake. One operation is accepted per clock unless the output stalls.
// Latency from the accepting edge to OUT_VALID is LEVELS+2 clocks.
// Ports:
//   CLK  clock, rising edge
//   RST  synchronous active-high reset (clears all valid bits and outputs)
//   io   ks_pipe_adder_if.slave : IN_VALID/IN_READY, A, B, CIN, SUB,
//        OUT_VALID/OUT_READY, SUM, COUT, OVF
// ---------------------------------------------------------------------------
module ks_pipe_adder #(
    parameter int WIDTH = 16
) (
    input  logic           CLK,
    input  logic           RST,
    ks_pipe_adder_if.slave io
);
    localparam int LEVELS = $clog2(WIDTH);

    // One Kogge-Stone level at distance d, returned as {G, P}. Bits below d
    // pass through: the shifted operands are zero there, and the low mask
    // keeps P intact.
    function automatic logic [2*WIDTH-1:0] prefix_level(
        input logic [WIDTH-1:0] g,
        input logic [WIDTH-1:0] p,
        input int               d
    );
        logic [WIDTH-1:0] low;
        logic [WIDTH-1:0] gn;
        logic [WIDTH-1:0] pn;
        low = ~({WIDTH{1'b1}} << d);
        gn  = g | (p & (g << d));
        pn  = p & ((p << d) | low);
        return {gn, pn};
    endfunction

    logic en;

    logic             vld_p0;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] bx_p0;
    logic             c0_p0;

    logic [WIDTH-1:0] pg_p;
    logic [WIDTH-1:0] pg_g;

    // Index 0 is the P/G bank, indices 1..LEVELS the prefix levels.
    logic             vld_pk [0:LEVELS];
    logic [WIDTH-1:0] g_pk   [0:LEVELS];
    logic [WIDTH-1:0] p_pk   [0:LEVELS];
    logic [WIDTH-1:0] pi_pk  [0:LEVELS];
    logic             c0_pk  [0:LEVELS];

    logic [WIDTH-1:0] g_nx   [1:LEVELS];
    logic [WIDTH-1:0] p_nx   [1:LEVELS];

    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_nx;

    logic             out_vld_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    // Whole pipeline advances together; a stalled valid output freezes it.
    assign en          = ~out_vld_q | io.OUT_READY;
    assign io.IN_READY = en;

    // ---- stage 0 -> P/G bank ----
    // Carry-in is folded into bit 0 so the group generate G(i:0) after the
    // last level is the true carry out of bit i. The group propagate of
    // bit 0 includes P(-1)=0 and is therefore 0.
    assign pg_p = a_p0 ^ bx_p0;
    assign pg_g = (a_p0 & bx_p0) | {{(WIDTH-1){1'b0}}, pg_p[0] & c0_p0};

    // ---- prefix levels ----
    always_comb begin
        for (int k = 1; k <= LEVELS; k++) begin
            {g_nx[k], p_nx[k]} = prefix_level(g_pk[k-1], p_pk[k-1], 1 << (k - 1));
        end
    end

    // ---- output stage ----
    assign carry  = g_pk[LEVELS];
    assign sum_nx = pi_pk[LEVELS] ^ {carry[WIDTH-2:0], c0_pk[LEVELS]};

    // Datapath registers: only the enable gates them; their contents are
    // meaningful only where the matching valid bit is set.
    always_ff @(posedge CLK) begin
        if (en) begin
            a_p0     <= io.A;
            bx_p0    <= io.SUB ? ~io.B : io.B;
            c0_p0    <= io.SUB | io.CIN;

            g_pk[0]  <= pg_g;
            p_pk[0]  <= {pg_p[WIDTH-1:1], 1'b0};
            pi_pk[0] <= pg_p;
            c0_pk[0] <= c0_p0;

            for (int k = 1; k <= LEVELS; k++) begin
                g_pk[k]  <= g_nx[k];
                p_pk[k]  <= p_nx[k];
                pi_pk[k] <= pi_pk[k-1];
                c0_pk[k] <= c0_pk[k-1];
            end
        end
    end

    // Valid chain and result registers. Results load only for real beats so
    // bubbles never disturb the last presented result.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p0 <= 1'b0;
            for (int k = 0; k <= LEVELS; k++) begin
                vld_pk[k] <= 1'b0;
            end
            out_vld_q <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (en) begin
            vld_p0    <= io.IN_VALID;
            vld_pk[0] <= vld_p0;
            for (int k = 1; k <= LEVELS; k++) begin
                vld_pk[k] <= vld_pk[k-1];
            end
            out_vld_q <= vld_pk[LEVELS];
            if (vld_pk[LEVELS]) begin
                sum_q  <= sum_nx;
                cout_q <= carry[WIDTH-1];
                ovf_q  <= carry[WIDTH-1] ^ carry[WIDTH-2];
            end
        end
    end

    assign io.OUT_VALID = out_vld_q;
    assign io.SUM       = sum_q;
    assign io.COUT      = cout_q;
    assign io.OVF       = ovf_q;

endmodule

// File: tb/tb_ks_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_ks_pipe_adder
// Bench for ks_pipe_adder: a WIDTH=16 instance with directed vectors and a
// reset-mid-stream scenario, plus WIDTH=8/32/64 instances driven with
// random handshakes against a reference model. Expected results are queued
// when a beat is accepted; per-instance monitors pop and compare on every
// output transfer.
// ---------------------------------------------------------------------------
module tb_ks_pipe_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst16;
    logic rst_r;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- WIDTH = 16 instance ----------------
    ks_pipe_adder_if #(.WIDTH(16)) b16();
    ks_pipe_adder #(.WIDTH(16)) dut16 (.CLK(clk), .RST(rst16), .io(b16));

    logic [17:0] q16[$];   // {COUT, OVF, SUM}

    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (b16.OUT_VALID && b16.OUT_READY) begin
                if (q16.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected16: got 0x%0h, expected no result", {b16.COUT, b16.OVF, b16.SUM});
                end else begin
                    e = q16.pop_front();
                    chk("res16", {b16.COUT, b16.OVF, b16.SUM}, e);
                end
            end
        end
    end

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub, input logic [17:0] exp);
        int  n;
        bit  seen;
        @(negedge clk);
        b16.A = a; b16.B = b; b16.CIN = cin; b16.SUB = sub;
        b16.IN_VALID = 1'b1; b16.OUT_READY = 1'b1;
        #1;
        chk("in_ready16", b16.IN_READY, 1'b1);
        q16.push_back(exp);
        @(posedge clk);
        #1;
        b16.IN_VALID = 1'b0;
        n = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            n++;
            #1;
            if (b16.OUT_VALID) seen = 1;
        end
        chk("latency16", n, 6);
        @(negedge clk);
        #3;
    endtask

    task automatic stream16(input bit stall);
        int          sent = 0;
        int          stall_left = 3;
        int          first = -1;
        int          last = -1;
        bit          ok = 0;
        logic [15:0] held = '0;
        for (int cyc = 0; cyc < 60 && !ok; cyc++) begin
            @(negedge clk);
            if (stall && b16.OUT_VALID && stall_left > 0) begin
                b16.OUT_READY = 1'b0;
                if (stall_left == 3) held = b16.SUM;
                else chk("bp_sum_hold", b16.SUM, held);
                stall_left--;
            end else begin
                b16.OUT_READY = 1'b1;
            end
            if (b16.OUT_VALID) begin
                if (first < 0) first = cyc;
                last = cyc;
            end
            b16.IN_VALID = (sent < 8);
            b16.A   = 16'(sent);
            b16.B   = 16'(3 * sent);
            b16.CIN = sent[0];
            b16.SUB = 1'b0;
            #1;
            if (!b16.OUT_READY) chk("bp_in_ready", b16.IN_READY, 1'b0);
            if (b16.IN_VALID && b16.IN_READY) begin
                q16.push_back({2'b00, 16'(4 * sent + (sent & 1))});
                sent++;
            end
            #2;
            if (sent == 8 && q16.size() == 0) ok = 1;
        end
        b16.IN_VALID = 1'b0;
        chk("stream_done", ok, 1'b1);
        if (!stall) chk("stream_contig", last - first + 1, 8);
    endtask

    // ---------------- random-sweep instances ----------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
        localparam int W = (gi == 0) ? 8 : (gi == 1) ? 32 : 64;

        ks_pipe_adder_if #(.WIDTH(W)) bus();
        ks_pipe_adder #(.WIDTH(W)) dut (.CLK(clk), .RST(rst_r), .io(bus));

        logic [W+1:0] q[$];
        bit           done = 0;

        function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                                 input logic cin, input logic sub);
            logic [W-1:0] bp;
            logic [W:0]   t;
            logic         c0;
            logic         ovf;
            bp  = sub ? ~b : b;
            c0  = sub ? 1'b1 : cin;
            t   = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, c0};
            ovf = (a[W-1] == bp[W-1]) && (t[W-1] != a[W-1]);
            return {t[W], ovf, t[W-1:0]};
        endfunction

        function automatic logic [W-1:0] rnd_op();
            logic [63:0] r;
            r = {$urandom(), $urandom()};
            case ($urandom_range(7))
                0: return '0;
                1: return '1;
                2: return {1'b0, {(W-1){1'b1}}};
                3: return {1'b1, {(W-1){1'b0}}};
                default: return r[W-1:0];
            endcase
        endfunction

        initial begin
            int sent = 0;
            bit drained = 0;
            bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b0;
            bus.A = '0; bus.B = '0; bus.CIN = 1'b0; bus.SUB = 1'b0;
            @(negedge clk);
            while (rst_r) @(negedge clk);
            for (int c = 0; c < 3000 && sent < 150; c++) begin
                @(negedge clk);
                bus.OUT_READY = ($urandom_range(3) != 0);
                bus.IN_VALID  = ($urandom_range(2) != 0);
                bus.A   = rnd_op();
                bus.B   = rnd_op();
                bus.CIN = 1'($urandom_range(1));
                bus.SUB = 1'($urandom_range(1));
                #1;
                if (bus.IN_VALID && bus.IN_READY) begin
                    q.push_back(ref_add(bus.A, bus.B, bus.CIN, bus.SUB));
                    sent++;
                end
            end
            @(negedge clk);
            bus.IN_VALID  = 1'b0;
            bus.OUT_READY = 1'b1;
            for (int c = 0; c < 60 && !drained; c++) begin
                @(negedge clk);
                #3;
                if (q.size() == 0) drained = 1;
            end
            chk($sformatf("drain_w%0d", W), drained, 1'b1);
            chk($sformatf("count_w%0d", W), sent, 150);
            done = 1;
        end

        initial begin
            logic [W+1:0] e;
            forever begin
                @(negedge clk);
                #2;
                if (bus.OUT_VALID && bus.OUT_READY) begin
                    if (q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_w%0d: got 0x%0h, expected no result", W, bus.SUM);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("res_w%0d", W), {bus.COUT, bus.OVF, bus.SUM}, e);
                    end
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int  cnt;
        bit  all_done;
        rst16 = 1'b1; rst_r = 1'b1;
        b16.IN_VALID = 1'b0; b16.OUT_READY = 1'b1;
        b16.A = '0; b16.B = '0; b16.CIN = 1'b0; b16.SUB = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", b16.OUT_VALID, 1'b0);
        chk("rst_sum", b16.SUM, 16'h0000);
        chk("rst_cout_ovf", {b16.COUT, b16.OVF}, 2'b00);
        @(negedge clk);
        rst16 = 1'b0; rst_r = 1'b0;
        #1;
        chk("rst_in_ready", b16.IN_READY, 1'b1);

        send16(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000});
        send16(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000});
        send16(16'h0003, 16'h0005, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});
        send16(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
        send16(16'h0005, 16'h0003, 1'b0, 1'b1, {1'b1, 1'b0, 16'h0002});
        send16(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, {1'b1, 1'b0, 16'hFFFF});

        stream16(1'b0);
        stream16(1'b1);

        // Four beats in flight, then reset with one more beat offered.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b16.IN_VALID = 1'b1; b16.OUT_READY = 1'b1;
            b16.A = 16'(16'h1000 + i); b16.B = 16'h0001; b16.CIN = 1'b0; b16.SUB = 1'b0;
        end
        @(negedge clk);
        rst16 = 1'b1;
        q16.delete();
        b16.A = 16'h2222;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", b16.OUT_VALID, 1'b0);
        chk("midrst_sum", b16.SUM, 16'h0000);
        @(negedge clk);
        rst16 = 1'b0;
        b16.IN_VALID = 1'b0;
        #1;
        chk("midrst_in_ready", b16.IN_READY, 1'b1);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (b16.OUT_VALID) cnt++;
        end
        chk("midrst_flush", cnt, 0);
        send16(16'h1234, 16'h4321, 1'b0, 1'b0, {1'b0, 1'b0, 16'h5555});

        all_done = 0;
        for (int c = 0; c < 10000 && !all_done; c++) begin
            @(negedge clk);
            all_done = g_rnd[0].done && g_rnd[1].done && g_rnd[2].done;
        end
        chk("random_sweep_done", all_done, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
